// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and hex-to-segment lookup for the
// seven-segment scan controller.
package seg7_pkg;

  localparam int SRC_W      = 32;
  localparam int BCD_DIGITS = 10;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high segments, bit7 = dp (never lit), bits 6..0 = g..a
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle between the value source and the scan controller.
interface seg7_scan_ctrl_if;
  import seg7_pkg::*;

  logic [SRC_W-1:0] value;
  logic             dec_mode;
  logic             blank_lz;
  logic [7:0]       seg;
  logic [2:0]       del;
  logic             busy;
  logic             ovf;

  modport master (
    output value, dec_mode, blank_lz,
    input  seg, del, busy, ovf
  );

  modport slave (
    input  value, dec_mode, blank_lz,
    output seg, del, busy, ovf
  );

endinterface

// File: rtl/seg7_scan_ctrl_bin2bcd_seq.sv
// Sequential double-dabble: 32-bit binary to 10 BCD digits, one bit per clk.
// Result is valid in o_bcd while o_done pulses, 32 clk after the start edge.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [SRC_W-1:0] i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [BCD_W-1:0] o_bcd
);

  logic [SRC_W-1:0]       r_src;
  logic [BCD_W-1:0]       r_bcd;
  logic [4:0]             r_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic [BCD_W-1:0]       w_adj;
  logic [BCD_W+SRC_W-1:0] w_shift;

  // NOTE: w_adj takes its default before the loop so no path leaves it unassigned.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  assign w_shift = {w_adj, r_src} << 1;

  // NOTE: state registers use non-blocking assignment only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_src  <= i_bin;
        r_bcd  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_bcd <= w_shift[BCD_W+SRC_W-1:SRC_W];
        r_src <= w_shift[SRC_W-1:0];
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Seven-segment scan controller: captures the displayed value, converts to
// hex or decimal digits, and multiplexes them onto one segment bus.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic           clk,
  input  logic           rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int             PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]     IDX_LAST = 3'(NUM_DIGITS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [SRC_W-1:0] r_shown_value;
  logic             r_shown_mode;
  logic [3:0]       r_digit [8];
  logic             r_ovf;
  logic [PW-1:0]    r_prescale;
  logic [2:0]       r_idx;
  logic [7:0]       r_seg;
  logic [2:0]       r_del;

  logic             w_capture;
  logic             w_start;
  logic             w_load_hex;
  logic             w_load_dec;
  logic [BCD_W-1:0] w_bcd;
  logic             w_bcd_busy;
  logic             w_bcd_done;
  logic             w_hex_ovf;
  logic             w_dec_ovf;
  logic [7:0]       w_blank;
  logic             w_zero_run;
  logic [7:0]       w_seg_next;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_bin   (bus.value),
    .o_busy  (w_bcd_busy),
    .o_done  (w_bcd_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Inputs are only compared in IDLE, so a change during CONV is picked up
  // on the first IDLE cycle after the result lands.
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_start    = 1'b0;
    w_load_hex = 1'b0;
    w_load_dec = 1'b0;
    case (r_state)
      IDLE: begin
        if ((bus.value != r_shown_value) || (bus.dec_mode != r_shown_mode)) begin
          w_capture = 1'b1;
          if (bus.dec_mode) begin
            w_start = 1'b1;
            w_next  = CONV;
          end else begin
            w_load_hex = 1'b1;
          end
        end
      end
      CONV: begin
        if (w_bcd_done) begin
          w_load_dec = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_hex_ovf = |(bus.value >> (4 * NUM_DIGITS));
  assign w_dec_ovf = |(w_bcd >> (4 * NUM_DIGITS));

  // NOTE: the digit array is small and must read as zero after reset, so every entry is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shown_value <= '0;
      r_shown_mode  <= 1'b0;
      r_ovf         <= 1'b0;
      for (int k = 0; k < 8; k++) r_digit[k] <= 4'd0;
    end else begin
      if (w_capture) begin
        r_shown_value <= bus.value;
        r_shown_mode  <= bus.dec_mode;
      end
      if (w_load_hex) begin
        for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= bus.value[4*k +: 4];
        r_ovf <= w_hex_ovf;
      end else if (w_load_dec) begin
        for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= w_bcd[4*k +: 4];
        r_ovf <= w_dec_ovf;
      end
    end
  end

  // A digit is blank when it and every displayed digit above it are zero.
  always_comb begin
    w_zero_run = 1'b1;
    w_blank    = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_zero_run = w_zero_run && (r_digit[k] == 4'd0);
      w_blank[k] = w_zero_run;
    end
  end

  assign w_seg_next = (bus.blank_lz && w_blank[r_idx]) ? SEG_BLANK
                                                       : hex_to_seg(r_digit[r_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale <= '0;
      r_idx      <= '0;
      r_seg      <= hex_to_seg(4'h0);
      r_del      <= '0;
    end else begin
      r_seg <= w_seg_next;
      r_del <= r_idx;
      if (r_prescale == PRE_LAST) begin
        r_prescale <= '0;
        r_idx      <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_prescale <= r_prescale + PW'(1);
      end
    end
  end

  assign bus.seg  = r_seg;
  assign bus.del  = r_del;
  assign bus.busy = w_bcd_busy;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed segment patterns.
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  enc [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  bit          m_valid = 1'b0;
  int unsigned m_cnt;
  logic [31:0] m_sv;
  logic        m_sm;
  int          m_left;
  logic [31:0] m_cv;
  logic [3:0]  m_dig [8];
  logic        m_ovf;
  logic [7:0]  e_seg;
  logic [2:0]  e_del;
  logic        e_busy;
  int          m_idx;
  int          m_msd;

  function automatic longint unsigned pow10(input int k);
    longint unsigned p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [3:0] dec_digit(input logic [31:0] v, input int k);
    longint unsigned q = {32'd0, v};
    return 4'((q / pow10(k)) % 10);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  = 0;
      m_sv   = '0;
      m_sm   = 1'b0;
      m_left = 0;
      m_cv   = '0;
      m_ovf  = 1'b0;
      for (int k = 0; k < 8; k++) m_dig[k] = 4'd0;
      e_seg  = 8'h3F;
      e_del  = 3'd0;
      e_busy = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      // Outputs reflect the scan position and digits held before this edge
      m_idx = int'((m_cnt / D) % N);
      m_msd = 0;
      for (int k = 0; k < N; k++) if (m_dig[k] != 4'd0) m_msd = k;
      e_seg = (bus.blank_lz && m_idx > m_msd) ? 8'h00 : enc[m_dig[m_idx]];
      e_del = 3'(m_idx);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          for (int k = 0; k < N; k++) m_dig[k] = dec_digit(m_cv, k);
          m_ovf = ({32'd0, m_cv} >= pow10(N));
        end
      end else if (bus.value !== m_sv || bus.dec_mode !== m_sm) begin
        m_sv = bus.value;
        m_sm = bus.dec_mode;
        if (m_sm) begin
          m_left = 33;
          m_cv   = m_sv;
        end else begin
          for (int k = 0; k < N; k++) m_dig[k] = m_sv[4*k +: 4];
          m_ovf = ((m_sv >> (4 * N)) != 0);
        end
      end
      e_busy = (m_left > 1);
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("seg", {24'd0, bus.seg}, {24'd0, e_seg});
      check("del", {29'd0, bus.del}, {29'd0, e_del});
      check("busy", {31'd0, bus.busy}, {31'd0, e_busy});
      check("ovf", {31'd0, bus.ovf}, {31'd0, m_ovf});
    end
  end

  // ---------------- directed helpers ----------------
  logic [7:0] seen [8];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int c = 0;
    while (bus.busy !== lvl && c < 200) begin
      @(negedge clk);
      c++;
    end
    check(name, {31'd0, bus.busy}, {31'd0, lvl});
  endtask

  task automatic scan();
    for (int i = 0; i < 8; i++) seen[i] = 8'hEE;
    repeat (N * D + 2) begin
      @(negedge clk);
      seen[bus.del] = bus.seg;
    end
  endtask

  task automatic check_scan(input string name, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    scan();
    check({name, "_d0"}, {24'd0, seen[0]}, {24'd0, s0});
    check({name, "_d1"}, {24'd0, seen[1]}, {24'd0, s1});
    check({name, "_d2"}, {24'd0, seen[2]}, {24'd0, s2});
    check({name, "_d3"}, {24'd0, seen[3]}, {24'd0, s3});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int c;
    logic [31:0] v;
    rst          = 1'b1;
    bus.value    = '0;
    bus.dec_mode = 1'b0;
    bus.blank_lz = 1'b0;

    // Reset and idle scan
    tick(2);
    check("rst_seg", {24'd0, bus.seg}, 32'h3F);
    check("rst_del", {29'd0, bus.del}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    tick(5);  check("idle_del_a", {29'd0, bus.del}, 32'd1);
    tick(4);  check("idle_del_b", {29'd0, bus.del}, 32'd2);
    tick(4);  check("idle_del_c", {29'd0, bus.del}, 32'd3);
    tick(4);  check("idle_del_d", {29'd0, bus.del}, 32'd0);

    // Hex display and overflow
    bus.value = 32'h0000_BEEF;
    tick(2);
    check("model_hex_d0", {28'd0, m_dig[0]}, 32'hF);
    check("model_hex_d3", {28'd0, m_dig[3]}, 32'hB);
    check_scan("hex_beef", 8'h71, 8'h79, 8'h79, 8'h7C);
    check("hex_beef_ovf", {31'd0, bus.ovf}, 32'd0);
    bus.value = 32'h0001_0000;
    tick(2);
    check_scan("hex_ovf", 8'h3F, 8'h3F, 8'h3F, 8'h3F);
    check("hex_ovf_flag", {31'd0, bus.ovf}, 32'd1);

    // Decimal conversion length and result
    bus.dec_mode = 1'b1;
    bus.value    = 32'd1234;
    wait_busy(1'b1, "dec_busy_rise");
    c = 0;
    while (bus.busy === 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("dec_busy_len", c, 32'd32);
    tick(3);
    check("model_dec_d1", {28'd0, m_dig[1]}, 32'd3);
    check_scan("dec_1234", 8'h66, 8'h4F, 8'h5B, 8'h06);
    check("dec_1234_ovf", {31'd0, bus.ovf}, 32'd0);
    bus.value = 32'd12345;
    wait_busy(1'b1, "dec2_busy_rise");
    wait_busy(1'b0, "dec2_busy_fall");
    tick(3);
    check_scan("dec_12345", 8'h6D, 8'h66, 8'h4F, 8'h5B);
    check("dec_12345_ovf", {31'd0, bus.ovf}, 32'd1);

    // Input change during conversion: 99 shown, then 7
    bus.value = 32'd99;
    wait_busy(1'b1, "chg_busy_rise");
    tick(10);
    bus.value = 32'd7;
    wait_busy(1'b0, "chg_busy_fall");
    tick(3);
    check_scan("chg_99", 8'h6F, 8'h6F, 8'h3F, 8'h3F);
    wait_busy(1'b1, "chg2_busy_rise");
    wait_busy(1'b0, "chg2_busy_fall");
    tick(3);
    check_scan("chg_7", 8'h07, 8'h3F, 8'h3F, 8'h3F);

    // Leading-zero blanking in hex
    bus.blank_lz = 1'b1;
    bus.dec_mode = 1'b0;
    bus.value    = 32'h0000_0030;
    tick(2);
    check_scan("blank_30", 8'h3F, 8'h4F, 8'h00, 8'h00);
    bus.value = 32'h0;
    tick(2);
    check_scan("blank_0", 8'h3F, 8'h00, 8'h00, 8'h00);

    // Reset in the middle of a conversion
    bus.blank_lz = 1'b0;
    bus.dec_mode = 1'b1;
    bus.value    = 32'd4294967295;
    wait_busy(1'b1, "rstc_busy_rise");
    tick(20);
    rst = 1'b1;
    tick(1);
    check("rstc_busy", {31'd0, bus.busy}, 32'd0);
    check("rstc_seg", {24'd0, bus.seg}, 32'h3F);
    check("rstc_del", {29'd0, bus.del}, 32'd0);
    check("rstc_ovf", {31'd0, bus.ovf}, 32'd0);
    rst = 1'b0;
    wait_busy(1'b1, "rstc2_busy_rise");
    wait_busy(1'b0, "rstc2_busy_fall");
    tick(3);
    check_scan("dec_max", 8'h6D, 8'h6F, 8'h5B, 8'h07);
    check("dec_max_ovf", {31'd0, bus.ovf}, 32'd1);

    // Randomized traffic, checked cycle by cycle against the model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = 32'($urandom_range(0, 9999));
        2:       v = 32'($urandom_range(0, 65535));
        default: v = bus.value;
      endcase
      bus.value    = v;
      bus.dec_mode = 1'($urandom_range(0, 1));
      bus.blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick($urandom_range(1, 50));
    end
    tick(80);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
